// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset defaults,
// FSM state encoding and the next-PC selection helper.
package instruction_fetch_unit_pkg;

    localparam int INSTRUCTION_WIDTH = 16;
    localparam int ADDRESS_WIDTH = 16;
    localparam logic [ADDRESS_WIDTH-1:0] RESET_VECTOR_DEFAULT = 16'h0000;
    localparam int unsigned FETCH_TIMEOUT_DEFAULT = 32'd255;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_EXECUTE  = 3'd2,
        ST_HALTED   = 3'd3,
        ST_FAULT    = 3'd4
    } fetch_state_e;

    // Next sequential or jump address; sequential arithmetic wraps modulo 2^16.
    function automatic logic [ADDRESS_WIDTH-1:0] next_pc(
        input logic [ADDRESS_WIDTH-1:0] pc,
        input logic                     increment,
        input logic [ADDRESS_WIDTH-1:0] jump_target
    );
        logic [ADDRESS_WIDTH-1:0] result;
        if (increment) begin
            result = pc + 16'd1;
        end else begin
            result = jump_target;
        end
        return result;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_program_counter_register.sv
// Program counter storage: async reset to the reset vector, and on a load
// either steps to the next sequential word or takes the jump target.
module program_counter_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load_enable,
    input  logic                     increment,
    input  logic [ADDRESS_WIDTH-1:0] jump_target,
    output logic [ADDRESS_WIDTH-1:0] program_counter
);

    logic [ADDRESS_WIDTH-1:0] pc_r;

    // Hold the PC; update only when the fetch FSM retires an instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= RESET_VECTOR;
        end else if (load_enable) begin
            pc_r <= next_pc(pc_r, increment, jump_target);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign program_counter = pc_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction word per
// req/ack transaction, presents it to the decoder until the datapath signals
// completion, then advances the PC. A fetch that is never acknowledged within
// FETCH_TIMEOUT cycles latches a sticky fault that only reset clears.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = RESET_VECTOR_DEFAULT,
    parameter int unsigned              FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset_n,
    output logic                         mem_req,
    output logic [ADDRESS_WIDTH-1:0]     mem_addr,
    input  logic                         mem_ack,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         instruction_valid,
    input  logic                         execute_done,
    input  logic                         program_counter_increment,
    input  logic [ADDRESS_WIDTH-1:0]     jump_target,
    input  logic                         halt,
    output logic [ADDRESS_WIDTH-1:0]     program_counter,
    output logic                         fault
);

    // Compare in 17 bits so a timeout of 65535 cannot overflow the counter.
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(FETCH_TIMEOUT);

    fetch_state_e                   state_r;
    logic                           mem_req_r;
    logic [INSTRUCTION_WIDTH-1:0]   instruction_r;
    logic                           instruction_valid_r;
    logic                           fault_r;
    logic [15:0]                    timeout_count_r;
    logic [16:0]                    timeout_count_next_s;
    logic                           timeout_hit_s;
    logic                           pc_load_s;
    logic [ADDRESS_WIDTH-1:0]       pc_s;

    assign timeout_count_next_s = {1'b0, timeout_count_r} + 17'd1;
    assign timeout_hit_s        = (timeout_count_next_s >= TIMEOUT_LIMIT);

    // The PC only moves when the current instruction retires.
    assign pc_load_s = (state_r == ST_EXECUTE) && execute_done;

    program_counter_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_program_counter_register (
        .clock           (clock),
        .reset_n         (reset_n),
        .load_enable     (pc_load_s),
        .increment       (program_counter_increment),
        .jump_target     (jump_target),
        .program_counter (pc_s)
    );

    // Fetch sequencing, timeout supervision and all registered handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r             <= ST_FETCH;
            mem_req_r           <= 1'b0;
            instruction_r       <= 16'h0000;
            instruction_valid_r <= 1'b0;
            fault_r             <= 1'b0;
            timeout_count_r     <= 16'd0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (halt) begin
                        mem_req_r <= 1'b0;
                        state_r   <= ST_HALTED;
                    end else begin
                        mem_req_r       <= 1'b1;
                        timeout_count_r <= 16'd0;
                        state_r         <= ST_WAIT_MEM;
                    end
                end
                ST_WAIT_MEM: begin
                    // An ack in the final timeout cycle still wins over the fault.
                    if (mem_ack) begin
                        instruction_r       <= mem_rdata;
                        instruction_valid_r <= 1'b1;
                        mem_req_r           <= 1'b0;
                        state_r             <= ST_EXECUTE;
                    end else if (timeout_hit_s) begin
                        timeout_count_r <= timeout_count_next_s[15:0];
                        mem_req_r       <= 1'b0;
                        fault_r         <= 1'b1;
                        state_r         <= ST_FAULT;
                    end else begin
                        timeout_count_r <= timeout_count_next_s[15:0];
                    end
                end
                ST_EXECUTE: begin
                    if (execute_done) begin
                        instruction_valid_r <= 1'b0;
                        if (halt) begin
                            state_r <= ST_HALTED;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_EXECUTE;
                    end
                end
                ST_HALTED: begin
                    mem_req_r           <= 1'b0;
                    instruction_valid_r <= 1'b0;
                    if (halt) begin
                        state_r <= ST_HALTED;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    mem_req_r           <= 1'b0;
                    instruction_valid_r <= 1'b0;
                    fault_r             <= 1'b1;
                end
                default: begin
                    // Unreachable encodings are treated as a fault: stop fetching.
                    mem_req_r           <= 1'b0;
                    instruction_valid_r <= 1'b0;
                    fault_r             <= 1'b1;
                    state_r             <= ST_FAULT;
                end
            endcase
        end
    end

    assign mem_req           = mem_req_r;
    assign mem_addr          = pc_s;
    assign instruction       = instruction_r;
    assign instruction_valid = instruction_valid_r;
    assign program_counter   = pc_s;
    assign fault             = fault_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. The bench plays both the
// instruction memory and the decoder/datapath, and keeps a transaction-level
// model of the program counter (sequential step or jump per retired word).
module tb_instruction_fetch_unit;

    localparam int unsigned TIMEOUT = 32'd4;
    localparam logic [15:0] RVEC = 16'h0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        instruction_valid;
    logic        execute_done;
    logic        program_counter_increment;
    logic [15:0] jump_target;
    logic        halt;
    logic [15:0] program_counter;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_pc;
    logic [15:0] model_word;

    instruction_fetch_unit #(
        .RESET_VECTOR  (RVEC),
        .FETCH_TIMEOUT (TIMEOUT)
    ) dut (
        .clock                     (clock),
        .reset_n                   (reset_n),
        .mem_req                   (mem_req),
        .mem_addr                  (mem_addr),
        .mem_ack                   (mem_ack),
        .mem_rdata                 (mem_rdata),
        .instruction               (instruction),
        .instruction_valid         (instruction_valid),
        .execute_done              (execute_done),
        .program_counter_increment (program_counter_increment),
        .jump_target               (jump_target),
        .halt                      (halt),
        .program_counter           (program_counter),
        .fault                     (fault)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From FETCH: one edge issues the request at the model PC.
    task automatic issue_fetch();
        mem_ack      = 1'b0;
        execute_done = 1'b0;
        tick();
        check_value("req_issued", 16'(mem_req), 16'd1);
        check_value("req_addr", mem_addr, model_pc);
        check_value("no_fault", 16'(fault), 16'd0);
    endtask

    // Withhold ack for 'delay' cycles (with stray execute_done noise), then ack.
    task automatic complete_fetch(input int delay, input logic [15:0] data);
        for (int i = 0; i < delay; i++) begin
            mem_ack      = 1'b0;
            execute_done = 1'($urandom_range(1, 0));
            tick();
            check_value("wait_req", 16'(mem_req), 16'd1);
            check_value("wait_addr", mem_addr, model_pc);
            check_value("wait_valid", 16'(instruction_valid), 16'd0);
        end
        execute_done = 1'b0;
        mem_ack      = 1'b1;
        mem_rdata    = data;
        tick();
        mem_ack    = 1'b0;
        mem_rdata  = 16'($urandom);
        model_word = data;
        check_value("ack_instr", instruction, data);
        check_value("ack_valid", 16'(instruction_valid), 16'd1);
        check_value("ack_req_drop", 16'(mem_req), 16'd0);
        check_value("ack_pc_held", program_counter, model_pc);
    endtask

    // Hold EXECUTE for 'delay' cycles with stray acks, then retire the word.
    task automatic execute(input int delay, input logic inc, input logic [15:0] target, input logic hlt);
        halt = hlt;
        for (int i = 0; i < delay; i++) begin
            execute_done = 1'b0;
            mem_ack      = 1'($urandom_range(1, 0));
            mem_rdata    = 16'($urandom);
            tick();
            check_value("exec_instr_held", instruction, model_word);
            check_value("exec_valid_held", 16'(instruction_valid), 16'd1);
            check_value("exec_no_req", 16'(mem_req), 16'd0);
        end
        mem_ack                   = 1'b0;
        execute_done              = 1'b1;
        program_counter_increment = inc;
        jump_target               = target;
        tick();
        execute_done              = 1'b0;
        program_counter_increment = 1'($urandom_range(1, 0));
        jump_target               = 16'($urandom);
        if (inc) model_pc = model_pc + 16'd1;
        else     model_pc = target;
        check_value("done_pc", program_counter, model_pc);
        check_value("done_valid", 16'(instruction_valid), 16'd0);
        check_value("done_no_req", 16'(mem_req), 16'd0);
        if (!hlt) halt = 1'b0;
    endtask

    // Keep halt high for n cycles; nothing must be fetched. Then release.
    task automatic halt_hold(input int n);
        halt = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check_value("halt_no_req", 16'(mem_req), 16'd0);
            check_value("halt_no_valid", 16'(instruction_valid), 16'd0);
            check_value("halt_pc_frozen", program_counter, model_pc);
        end
        halt = 1'b0;
        tick();
        check_value("unhalt_no_req_yet", 16'(mem_req), 16'd0);
    endtask

    task automatic run_instruction(input int ack_delay, input logic [15:0] data, input int exec_delay,
                                   input logic inc, input logic [15:0] target, input logic hlt);
        issue_fetch();
        complete_fetch(ack_delay, data);
        execute(exec_delay, inc, target, hlt);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        #2;
        reset_n = 1'b0;
        #1;
        check_value("rst_req_async", 16'(mem_req), 16'd0);
        check_value("rst_valid_async", 16'(instruction_valid), 16'd0);
        check_value("rst_pc_async", program_counter, RVEC);
        check_value("rst_fault_async", 16'(fault), 16'd0);
        tick();
        check_value("rst_req_held", 16'(mem_req), 16'd0);
        #2;
        reset_n  = 1'b1;
        model_pc = RVEC;
        halt     = 1'b0;
    endtask

    initial begin
        reset_n                   = 1'b0;
        mem_ack                   = 1'b0;
        mem_rdata                 = 16'h0000;
        execute_done              = 1'b0;
        program_counter_increment = 1'b1;
        jump_target               = 16'h0000;
        halt                      = 1'b0;
        model_pc                  = RVEC;
        model_word                = 16'h0000;

        #12;
        check_value("reset_pc", program_counter, RVEC);
        check_value("reset_instr", instruction, 16'h0000);
        check_value("reset_valid", 16'(instruction_valid), 16'd0);
        check_value("reset_req", 16'(mem_req), 16'd0);
        check_value("reset_fault", 16'(fault), 16'd0);
        #10;
        reset_n = 1'b1;

        // First word: ack one cycle after req -> valid on the third edge.
        run_instruction(1, 16'h1234, 0, 1'b0, 16'h0005, 1'b0);
        // PC=5 step -> 6, then jump to 0x40.
        run_instruction(0, 16'($urandom), 1, 1'b1, 16'hBEEF, 1'b0);
        run_instruction(2, 16'($urandom), 0, 1'b0, 16'h0040, 1'b0);
        // Wrap from 0xFFFF to 0x0000.
        run_instruction(0, 16'($urandom), 0, 1'b0, 16'hFFFF, 1'b0);
        run_instruction(0, 16'($urandom), 2, 1'b1, 16'h1111, 1'b0);
        // Ack in the last timeout cycle wins.
        run_instruction(TIMEOUT - 1, 16'hA5A5, 0, 1'b1, 16'h0000, 1'b0);
        // Halt during EXECUTE: PC still updates, then halted, then resume.
        run_instruction(1, 16'($urandom), 2, 1'b0, 16'h0300, 1'b1);
        halt_hold(3);
        run_instruction(0, 16'($urandom), 0, 1'b1, 16'h0000, 1'b0);
        // Halt seen at FETCH.
        halt_hold(2);

        // Randomized traffic against the PC model.
        for (int n = 0; n < 40; n++) begin
            logic hlt;
            hlt = ($urandom_range(7, 0) == 0);
            run_instruction($urandom_range(TIMEOUT - 1, 0), 16'($urandom), $urandom_range(3, 0),
                            1'($urandom_range(1, 0)), 16'($urandom), hlt);
            if (hlt) halt_hold($urandom_range(3, 1));
        end

        // Reset during WAIT_MEM, then fetch restarts from the reset vector.
        issue_fetch();
        reset_pulse();
        run_instruction(1, 16'h0F0F, 0, 1'b1, 16'h0000, 1'b0);

        // Reset during EXECUTE.
        issue_fetch();
        complete_fetch(0, 16'h7777);
        reset_pulse();
        run_instruction(0, 16'h3333, 0, 1'b0, 16'h0100, 1'b0);

        // Timeout: no ack for TIMEOUT cycles -> sticky fault, requests stop.
        issue_fetch();
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
            tick();
            check_value("to_wait_req", 16'(mem_req), 16'd1);
            check_value("to_wait_fault", 16'(fault), 16'd0);
        end
        tick();
        check_value("to_fault", 16'(fault), 16'd1);
        check_value("to_req_drop", 16'(mem_req), 16'd0);
        for (int i = 0; i < 3; i++) begin
            mem_ack      = 1'b1;
            mem_rdata    = 16'($urandom);
            execute_done = 1'b1;
            tick();
            check_value("fault_sticky", 16'(fault), 16'd1);
            check_value("fault_no_req", 16'(mem_req), 16'd0);
            check_value("fault_no_valid", 16'(instruction_valid), 16'd0);
            check_value("fault_pc_frozen", program_counter, model_pc);
        end
        mem_ack      = 1'b0;
        execute_done = 1'b0;
        reset_pulse();
        run_instruction(1, 16'hC0DE, 0, 1'b1, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
